// File: rtl/axis_rr_stream_arbiter.sv
// axis_rr_stream_arbiter: N AXI-Stream requesters share one registered
// output stage. Arbitration is round-robin per packet and the grant is held
// until the s_last beat of the granted requester is accepted.
// Optional build macro: AXIS_RR_ARB_PRIO0_EN gives requester 0 priority at
// each arbitration point (it never preempts a packet already in progress).
//
// Handshake: a beat moves on a channel in any cycle where valid and ready are
// both high at the rising edge. Valid never waits for ready, and the
// producer holds data/last stable while valid is high and ready is low. The
// output stage accepts a beat when it is empty or downstream is taking the
// current one (stage_ready = ~m_valid | m_ready).
module axis_rr_stream_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 32,
  parameter int ID_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          s_valid,
  output logic [N-1:0]          s_ready,
  input  logic [N*WIDTH-1:0]    s_data,
  input  logic [N-1:0]          s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic [ID_WIDTH-1:0]   m_id,
  output logic                  busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]          state;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] rr_ptr;

  logic                stage_ready;
  logic                accept;
  logic                sel_valid;
  logic                sel_last;
  logic [WIDTH-1:0]    sel_data;
  logic [ID_WIDTH-1:0] pick;
  logic                pick_found;

  assign stage_ready = ~m_valid | m_ready;
  // busy doubles as the externally visible FSM state (high in GRANT)
  assign busy        = (state == GRANT);
  assign accept      = busy & sel_valid & stage_ready;

  // Select the granted requester's channel and steer stage_ready back to it
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    s_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == ID_WIDTH'(i)) begin
        sel_valid  = s_valid[i];
        sel_last   = s_last[i];
        sel_data   = s_data[i*WIDTH +: WIDTH];
        s_ready[i] = busy & stage_ready;
      end
    end
  end

  // Round-robin search: first valid requester at or after rr_ptr+1 (mod N)
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!pick_found && s_valid[i] && (((int'(rr_ptr) + k) % N) == i)) begin
          pick       = ID_WIDTH'(i);
          pick_found = 1'b1;
        end
      end
    end
`ifdef AXIS_RR_ARB_PRIO0_EN
    // Requester 0 wins any arbitration it takes part in
    if (s_valid[0]) begin
      pick       = '0;
      pick_found = 1'b1;
    end
`endif
  end

  // Arbiter FSM: latch a pick in IDLE, release after the last beat is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= ID_WIDTH'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (accept && sel_last) begin
            rr_ptr <= grant;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage control: load on accept, empty when downstream takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_id    <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_last  <= sel_last;
      m_id    <= grant;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Output data register; no reset needed since m_valid qualifies it
  always_ff @(posedge clk) begin
    if (accept) begin
      m_data <= sel_data;
    end
  end

endmodule
